// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA configuration sequencer.
//   cfg_state_t : sequencer state encoding (2 bits)
//   cfg_entry_t : one buffered configuration word {last, addr, data}
//   CFG_ADDR_W / CFG_DATA_W : default config address/data widths
package cgra_cfg_pkg;

  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } cfg_state_t;

  typedef struct packed {
    logic                  last;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/cgra_config_sequencer_fifo.sv
// Synchronous word FIFO with flush, used to buffer host configuration words.
// Ports:
//   clk_in, reset_in : clock, asynchronous active-high reset
//   flush            : empties the FIFO on the next edge (wins over push/pop)
//   push, wdata      : write request and data (ignored when full)
//   pop, rdata       : read request (ignored when empty); rdata shows the head
//   full, empty      : occupancy flags from pointer-plus-wrap-bit compare
//   count            : current number of entries
module cfg_word_fifo
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cgra_config_sequencer.sv
// Sequences a configuration bitstream from a host valid/ready stream into the
// CGRA fabric, one word per cycle, then waits a settle interval and raises run.
// Ports:
//   clk_in, reset_in            : clock, asynchronous active-high reset
//   start_in, abort_in          : begin a load / return to idle and flush
//   cfg_valid_in, cfg_ready_out : host word handshake
//   cfg_addr_in, cfg_data_in    : host word, cfg_last_in marks the final word
//   config_addr_out/_data_out   : word presented to the fabric
//   config_en_out               : fabric write strobe, one cycle per word
//   busy_out, run_out           : loading/settling, configuration complete
//   word_count_out              : saturating count of words applied
//   err_out                     : sticky stray-word / discarded-word flag
//
// state  | meaning
// IDLE   | waiting for start, host stream not accepted
// LOAD   | accepting host words and applying them to the fabric
// SETTLE | last word applied, counting down the settle interval
// RUN    | configuration complete, fabric may run
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int ADDR_W        = CFG_ADDR_W,
  parameter int DATA_W        = CFG_DATA_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_en_out,
  output logic              busy_out,
  output logic              run_out,
  output logic [CNT_W-1:0]  word_count_out,
  output logic              err_out
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int FPW     = $clog2(FIFO_DEPTH);
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [FPW:0]     FIFO_ONE    = (FPW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  cfg_state_t state;
  cfg_state_t state_next;

  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [FPW:0]       fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               head_last;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               start_take;
  logic               last_pop;
  logic               discard;
  logic               stray_word;
  logic [SW-1:0]      settle_cnt;

  assign head_last = fifo_rdata[ENTRY_W-1];
  assign head_addr = fifo_rdata[DATA_W +: ADDR_W];
  assign head_data = fifo_rdata[DATA_W-1:0];
  assign fifo_wdata = {cfg_last_in, cfg_addr_in, cfg_data_in};

  assign start_take    = start_in && !abort_in && ((state == IDLE) || (state == RUN));
  assign cfg_ready_out = (state == LOAD) && !fifo_full;
  assign fifo_push     = cfg_valid_in && cfg_ready_out;
  // An abort cycle applies nothing, so the word count freezes where it was.
  assign fifo_pop      = (state == LOAD) && !fifo_empty && !abort_in;
  assign last_pop      = fifo_pop && head_last;
  // Anything queued behind the last word, or arriving with it, is dropped.
  assign discard       = last_pop && ((fifo_count > FIFO_ONE) || fifo_push);
  assign stray_word    = cfg_valid_in && ((state == IDLE) || (state == RUN));
  assign fifo_flush    = abort_in || start_take || last_pop;

  assign busy_out = (state == LOAD) || (state == SETTLE);
  assign run_out  = (state == RUN);

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wdata    (fifo_wdata),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort_in) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_in) state_next = LOAD;
        LOAD:    if (last_pop) state_next = SETTLE;
        SETTLE:  if (settle_cnt == '0) state_next = RUN;
        RUN:     if (start_in) state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      settle_cnt <= '0;
    end else if ((state == LOAD) && (state_next == SETTLE)) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SETTLE_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      config_addr_out <= '0;
      config_data_out <= '0;
      config_en_out   <= 1'b0;
      word_count_out  <= '0;
      err_out         <= 1'b0;
    end else begin
      config_en_out <= fifo_pop;
      if (fifo_pop) begin
        config_addr_out <= head_addr;
        config_data_out <= head_data;
      end
      if (start_take) begin
        word_count_out <= '0;
      end else if (fifo_pop && (word_count_out != '1)) begin
        word_count_out <= word_count_out + CNT_ONE;
      end
      if (start_take)                err_out <= 1'b0;
      else if (stray_word || discard) err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Randomized self-checking bench for cgra_config_sequencer. The reference model
// is the rule set of the block: words reach the fabric in acceptance order up to
// and including the first last-marked word, words after it are dropped and flag
// an error, and run rises a fixed settle interval after the final strobe.
module tb_cgra_config_sequencer;
  import cgra_cfg_pkg::*;

  localparam int AW     = CFG_ADDR_W;
  localparam int DW     = CFG_DATA_W;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 8;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          valid;
  logic          last;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ready;
  logic [AW-1:0] cfg_a;
  logic [DW-1:0] cfg_d;
  logic          en;
  logic          busy;
  logic          run;
  logic [CW-1:0] wcount;
  logic          err;

  cgra_config_sequencer #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CW)
  ) dut (
    .clk_in          (clk),
    .reset_in        (rst),
    .start_in        (start),
    .abort_in        (abort),
    .cfg_valid_in    (valid),
    .cfg_ready_out   (ready),
    .cfg_addr_in     (addr),
    .cfg_data_in     (data),
    .cfg_last_in     (last),
    .config_addr_out (cfg_a),
    .config_data_out (cfg_d),
    .config_en_out   (en),
    .busy_out        (busy),
    .run_out         (run),
    .word_count_out  (wcount),
    .err_out         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] obs_a [$];
  logic [DW-1:0] obs_d [$];
  int            obs_c [$];
  cfg_entry_t    pend_q [$];
  cfg_entry_t    acc_q [$];

  always @(negedge clk) begin
    if (en) begin
      obs_a.push_back(cfg_a);
      obs_d.push_back(cfg_d);
      obs_c.push_back(cyc);
    end
  end

  // Model: number of strobes the accepted words should produce.
  function automatic int model_len();
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i].last) return i + 1;
    return acc_q.size();
  endfunction

  function automatic logic model_err();
    return acc_q.size() > model_len();
  endfunction

  function automatic int order_errs(input int base);
    int e = 0;
    for (int i = 0; i < model_len(); i++) begin
      if (base + i >= obs_a.size()) e++;
      else if (obs_a[base+i] !== acc_q[i].addr || obs_d[base+i] !== acc_q[i].data) e++;
    end
    return e;
  endfunction

  function automatic cfg_entry_t mk_word(input logic l);
    cfg_entry_t w;
    w.last = l;
    w.addr = $urandom();
    w.data = $urandom();
    return w;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; last = 1'b0;
    addr = '0; data = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_pending(input int max_gap);
    while (pend_q.size() > 0) begin
      cfg_entry_t w;
      logic ok;
      w = pend_q.pop_front();
      valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) step();
      valid = 1'b1; last = w.last; addr = w.addr; data = w.data;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        if (ready) begin ok = 1'b1; break; end
        step();
      end
      if (!ok) begin
        total++; bad++;
        $display("FAIL send_timeout: ready=0 for 50 cycles, required 1");
      end else begin
        acc_q.push_back(w);
      end
      step();
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_run(output int rc);
    rc = -1;
    for (int t = 0; t < 200; t++) begin
      if (run) begin rc = cyc; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; last = 1'b0;
    addr = '0; data = '0;
    step();
    total++;
    if ({ready, en, busy, run, err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 00000", {ready, en, busy, run, err});
    end
    total++;
    if (wcount !== '0 || cfg_a !== '0 || cfg_d !== '0) begin
      bad++; $display("FAIL reset_values: count=%0d addr=%0h data=%0h required 0", wcount, cfg_a, cfg_d);
    end
    rst = 1'b0;
    step();
    valid = 1'b1;
    total++;
    if ({ready, busy, run} !== 3'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b required 000", {ready, busy, run});
    end
    valid = 1'b0;
  endtask

  task automatic test_basic();
    int base, n, rc;
    do_reset();
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    pend_q.push_back(cfg_entry_t'{1'b0, 32'h0000_0001, 32'hAAAA_0001});
    pend_q.push_back(cfg_entry_t'{1'b0, 32'h0000_0002, 32'hBBBB_0002});
    pend_q.push_back(cfg_entry_t'{1'b1, 32'h0000_0003, 32'hCCCC_0003});
    send_pending(0);
    wait_run(rc);
    n = obs_a.size() - base;
    total++;
    if (n !== 3) begin bad++; $display("FAIL basic_strobes: got %0d required 3", n); end
    total++;
    if (order_errs(base) !== 0) begin
      bad++; $display("FAIL basic_words: %0d words differ from pushed order", order_errs(base));
    end
    if (n >= 3) begin
      total++;
      if (obs_c[base+2] - obs_c[base] !== 2) begin
        bad++; $display("FAIL basic_consecutive: strobe span %0d required 2", obs_c[base+2] - obs_c[base]);
      end
      total++;
      if (rc - obs_c[base+n-1] !== SETTLE) begin
        bad++; $display("FAIL basic_settle: run after %0d cycles required %0d", rc - obs_c[base+n-1], SETTLE);
      end
    end
    total++;
    if (wcount !== 16'd3 || err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_status: count=%0d err=%b busy=%b required 3/0/0", wcount, err, busy);
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 4; it++) begin
      int base, n, k, rc;
      acc_q.delete();
      base = obs_a.size();
      start_pulse();
      total++;
      if (run !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL rand_start: run=%b busy=%b required 0/1", run, busy);
      end
      k = $urandom_range(6, 1);
      for (int i = 0; i < k; i++) pend_q.push_back(mk_word(i == k - 1));
      send_pending(2);
      wait_run(rc);
      n = obs_a.size() - base;
      total++;
      if (n !== model_len() || order_errs(base) !== 0) begin
        bad++; $display("FAIL rand_words: got %0d strobes (%0d bad) required %0d", n, order_errs(base), model_len());
      end
      total++;
      if (wcount !== CW'(model_len()) || err !== model_err()) begin
        bad++; $display("FAIL rand_status: count=%0d err=%b required %0d/%b", wcount, err, model_len(), model_err());
      end
      if (n > 0) begin
        total++;
        if (rc - obs_c[base+n-1] !== SETTLE) begin
          bad++; $display("FAIL rand_settle: run after %0d cycles required %0d", rc - obs_c[base+n-1], SETTLE);
        end
      end
    end
  endtask

  task automatic test_reconfig();
    int base, n, rc;
    total++;
    if (run !== 1'b1) begin bad++; $display("FAIL reconf_pre: run=%b required 1", run); end
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    total++;
    if (run !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL reconf_drop: run=%b busy=%b required 0/1", run, busy);
    end
    pend_q.push_back(mk_word(1'b1));
    send_pending(0);
    wait_run(rc);
    n = obs_a.size() - base;
    total++;
    if (n !== 1 || order_errs(base) !== 0) begin
      bad++; $display("FAIL reconf_word: got %0d strobes required 1 matching", n);
    end
    if (n > 0) begin
      total++;
      if (rc - obs_c[base+n-1] !== SETTLE) begin
        bad++; $display("FAIL reconf_settle: run after %0d cycles required %0d", rc - obs_c[base+n-1], SETTLE);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    int base, idx, n, rc;
    cfg_entry_t words [10];
    for (int i = 0; i < 10; i++) words[i] = mk_word(i == 9);
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    force dut.fifo_pop = 1'b0;
    idx = 0;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      valid = 1'b1; last = words[idx].last; addr = words[idx].addr; data = words[idx].data;
      if (c == 8) release dut.fifo_pop;
      if (c == 6) begin
        total++;
        if (idx !== DEPTH || ready !== 1'b0 || obs_a.size() !== base) begin
          bad++; $display("FAIL stall_full: queued=%0d ready=%b strobes=%0d required %0d/0/0", idx, ready, obs_a.size() - base, DEPTH);
        end
      end
      if (ready) begin acc_q.push_back(words[idx]); idx++; end
      step();
    end
    valid = 1'b0; last = 1'b0;
    wait_run(rc);
    n = obs_a.size() - base;
    total++;
    if (n !== 10 || order_errs(base) !== 0) begin
      bad++; $display("FAIL stall_order: got %0d strobes (%0d bad) required 10 in order", n, order_errs(base));
    end
    total++;
    if (wcount !== 16'd10 || err !== 1'b0) begin
      bad++; $display("FAIL stall_status: count=%0d err=%b required 10/0", wcount, err);
    end
  endtask

  task automatic test_leftover();
    int base, n, rc;
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    force dut.fifo_pop = 1'b0;
    pend_q.push_back(mk_word(1'b1));
    pend_q.push_back(mk_word(1'b0));
    send_pending(0);
    release dut.fifo_pop;
    wait_run(rc);
    n = obs_a.size() - base;
    total++;
    if (n !== model_len() || order_errs(base) !== 0) begin
      bad++; $display("FAIL leftover_words: got %0d strobes required %0d", n, model_len());
    end
    total++;
    if (err !== model_err() || wcount !== CW'(model_len())) begin
      bad++; $display("FAIL leftover_status: err=%b count=%0d required %b/%0d", err, wcount, model_err(), model_len());
    end
  endtask

  task automatic test_abort();
    int base, idx;
    logic done;
    cfg_entry_t words [5];
    for (int i = 0; i < 5; i++) words[i] = mk_word(i == 4);
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    idx = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (obs_a.size() - base >= 2) begin
        valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        done = 1'b1;
      end else begin
        if (idx < 5) begin
          valid = 1'b1; last = words[idx].last; addr = words[idx].addr; data = words[idx].data;
          if (ready) begin acc_q.push_back(words[idx]); idx++; end
        end else valid = 1'b0;
        step();
      end
    end
    valid = 1'b0; last = 1'b0;
    total++;
    if (!done || {busy, ready, en, run} !== 4'b0) begin
      bad++; $display("FAIL abort_state: reached=%b busy/ready/en/run=%b required 1/0000", done, {busy, ready, en, run});
    end
    total++;
    if (dut.u_fifo.empty !== 1'b1 || wcount !== 16'd2) begin
      bad++; $display("FAIL abort_flush: empty=%b count=%0d required 1/2", dut.u_fifo.empty, wcount);
    end
    total++;
    if (obs_a.size() - base < 2 || obs_a[base] !== words[0].addr || obs_a[base+1] !== words[1].addr) begin
      bad++; $display("FAIL abort_words: first two strobes differ from first two words");
    end
    repeat (10) step();
    total++;
    if (obs_a.size() - base !== 2 || wcount !== 16'd2 || run !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: strobes=%0d count=%0d run=%b required 2/2/0", obs_a.size() - base, wcount, run);
    end
  endtask

  task automatic test_idle_push();
    int base, rc;
    base = obs_a.size();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL idle_err_pre: err=%b required 0", err); end
    valid = 1'b1; addr = $urandom(); data = $urandom(); last = 1'b1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL idle_ready: ready=%b required 0", ready); end
    step(); step();
    valid = 1'b0;
    total++;
    if (err !== 1'b1 || obs_a.size() !== base || busy !== 1'b0) begin
      bad++; $display("FAIL idle_push: err=%b strobes=%0d busy=%b required 1/0/0", err, obs_a.size() - base, busy);
    end
    start_pulse();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_clears_err: err=%b busy=%b required 0/1", err, busy);
    end
    acc_q.delete();
    pend_q.push_back(mk_word(1'b1));
    send_pending(0);
    wait_run(rc);
    total++;
    if (rc < 0 || obs_a.size() - base !== 1 || err !== 1'b0) begin
      bad++; $display("FAIL idle_followup: run_cycle=%0d strobes=%0d err=%b required run/1/0", rc, obs_a.size() - base, err);
    end
  endtask

  task automatic test_reset_in_settle();
    int base;
    acc_q.delete();
    base = obs_a.size();
    start_pulse();
    pend_q.push_back(mk_word(1'b0));
    pend_q.push_back(mk_word(1'b1));
    send_pending(0);
    for (int t = 0; t < 20 && obs_a.size() - base < 2; t++) step();
    step(); step();
    total++;
    if (busy !== 1'b1 || run !== 1'b0 || en !== 1'b0) begin
      bad++; $display("FAIL settle_pre: busy=%b run=%b en=%b required 1/0/0", busy, run, en);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({run, busy, en, ready} !== 4'b0 || wcount !== '0) begin
      bad++; $display("FAIL async_reset: run/busy/en/ready=%b count=%0d required 0000/0", {run, busy, en, ready}, wcount);
    end
    step();
    rst = 1'b0;
    base = obs_a.size();
    repeat (15) step();
    total++;
    if (obs_a.size() !== base || run !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_quiet: strobes=%0d run=%b busy=%b required 0/0/0", obs_a.size() - base, run, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random_loads();
    test_reconfig();
    test_back_to_back_stall();
    test_leftover();
    test_abort();
    test_idle_push();
    test_reset_in_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
Sequences the bitstream load into the CGRA fabric. It accepts (address, data) configuration words from a host stream through a valid/ready handshake and buffers them in a small FIFO. It then applies them to the fabric's config_addr/config_data inputs at one word per cycle, with an enable strobe. After the last word and a programmable settle interval it asserts run_out, which gates application pad data into the array.

Parameters:
ADDR_W, 32, config address width
DATA_W, 32, config data width
FIFO_DEPTH, 4, word buffer depth (power of two, >=2)
SETTLE_CYCLES, 8, idle cycles between last word applied and run_out (>=1)
CNT_W, 16, width of word counter

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous active-high reset
start_in  in  1  one-cycle pulse; begins a load from IDLE
abort_in  in  1  returns to IDLE from any state, flushes FIFO
cfg_valid_in  in  1  host word valid
cfg_ready_out  out  1  block can accept word (= FIFO not full)
cfg_addr_in  in  ADDR_W  host config address
cfg_data_in  in  DATA_W  host config data
cfg_last_in  in  1  marks final word of bitstream
config_addr_out  out  ADDR_W  address to fabric
config_data_out  out  DATA_W  data to fabric
config_en_out  out  1  fabric write strobe, 1 cycle per word
busy_out  out  1  state is LOAD or SETTLE
run_out  out  1  configuration complete; fabric may run
word_count_out  out  CNT_W  words applied since last start (saturating)
err_out  out  1  sticky: word pushed while not in LOAD

Behaviour:
- Reset (async, reset_in=1): state IDLE, FIFO empty, all outputs 0 except cfg_ready_out=0. Release takes effect on the next clk_in rising edge.
- States IDLE, LOAD, SETTLE, RUN; 2-bit encoding.
- IDLE: cfg_ready_out=0. A start_in pulse causes the transition to LOAD, clears word_count_out and err_out, and empties the FIFO.
- LOAD: cfg_ready_out = !full. A push occurs when cfg_valid_in && cfg_ready_out; {last,addr,data} are written. A pop occurs whenever the FIFO is non-empty, one word per cycle. The popped word is registered onto config_addr_out/config_data_out with config_en_out=1 in the following cycle, so latency from push to strobe is 2 cycles when the FIFO is empty. Push and pop in the same cycle are legal; occupancy is unchanged. A full FIFO deasserts ready even if a pop happens that cycle, so ready never depends combinationally on the pop.
- Each pop increments word_count_out, which saturates at 2^CNT_W-1.
- When a word with last=1 is popped, the state goes to SETTLE on the next edge, and cfg_ready_out drops in that same cycle. Any words still in the FIFO behind the last word are discarded and set err_out.
- SETTLE: config_en_out=0. A down-counter is loaded with SETTLE_CYCLES-1 and decrements each cycle. At 0 the state goes to RUN.
- RUN: run_out=1 and is held. start_in re-enters LOAD and clears run_out in the same edge (reconfiguration).
- config_addr_out/config_data_out hold their last value while config_en_out=0.
- abort_in has priority over start_in and all other transitions. It moves to IDLE, flushes the FIFO, and clears run_out and config_en_out. word_count_out and err_out are kept for debug.
- cfg_valid_in asserted outside LOAD is not accepted (ready=0). It sets err_out only if it is held in IDLE/RUN for the cycle after a start request is not pending; the sticky flag is cleared only by start_in or reset.
- start_in is ignored in LOAD/SETTLE.
- Reset asserted mid-load: all state is lost immediately, no further config_en_out strobes.

Decomposition:
- Package cgra_cfg_pkg: state enum {IDLE, LOAD, SETTLE, RUN}, default ADDR_W/DATA_W constants, and the FIFO entry struct {last, addr, data}.
- Sub-module cfg_word_fifo: synchronous FIFO with parameterized depth and width and a flush input. It uses pointer-plus-extra-bit full/empty and the same clk_in/reset_in.
- The top contains the FSM, settle counter, output registers and word counter.

Test Plan:
- Reset then start, push 3 words (0x00000001/0xAAAA0001, 0x00000002/0xBBBB0002, 0x00000003/0xCCCC0003 last) back-to-back -> config_en_out high 3 consecutive cycles with matching addr/data, word_count_out=3, run_out rises exactly SETTLE_CYCLES=8 cycles after the final strobe.
- Host holds valid for 10 words while the fabric path is stalled by an injected FIFO-full condition (DEPTH=4) -> cfg_ready_out low when 4 entries are queued, no word lost or duplicated, strobe order equals push order.
- Abort asserted mid-LOAD after 2 of 5 words -> next cycle state IDLE, config_en_out=0, FIFO empty, run_out=0, word_count_out stays 2.
- Push while IDLE (no start) -> cfg_ready_out=0, no strobe, err_out=1; next start_in clears err_out to 0.
- In RUN, assert start_in, load 1 word with last=1 -> run_out drops on the start edge, one strobe, run_out reasserts after 8 settle cycles.
- Assert reset_in asynchronously between clock edges during SETTLE -> run_out/busy_out/config_en_out go 0 immediately, with no strobe after release until a new start.
